// File: rtl/xcore_if_bim_ctrl.sv
// BIM counter table controller: post-reset clear sweep, commit-update FIFO with
// saturating read-modify-write, and arbitration of the shared RAM read port.
module xcore_if_bim_ctrl #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  INIT_VAL   = 2'b01,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_bpu_req,
  input  logic [ADDR_W-1:0] i_bpu_addr,
  output logic              o_bpu_valid,
  output logic [1:0]        o_bpu_bits,
  input  logic              i_cmt_valid,
  input  logic [ADDR_W-1:0] i_cmt_addr,
  input  logic              i_cmt_taken,
  output logic              o_cmt_ready,
  output logic [ADDR_W-1:0] o_ram_raddr,
  input  logic [1:0]        i_ram_rdata,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic [1:0]        o_ram_wdata,
  output logic              o_init_done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              taken;
  } upd_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  upd_t              fifo_q [FIFO_DEPTH];
  upd_t              fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [1:0]        ram_wdata_q, ram_wdata_d;
  logic              init_done_q, init_done_d;
  logic              cmt_ready_q, cmt_ready_d;
  logic              upd_rd, push, pop;
  upd_t              head;

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    starve_d    = starve_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    init_done_d = init_done_q;
    upd_rd      = 1'b0;
    pop         = 1'b0;
    push        = i_cmt_valid && cmt_ready_q;
    head        = fifo_q[rd_ptr_q];

    case (state_q)
      INIT: begin
        ram_we_d    = 1'b1;
        ram_waddr_d = sweep_q;
        ram_wdata_d = INIT_VAL;
        sweep_d     = sweep_q + ADDR_W'(1);
        if (sweep_q == ADDR_W'(DEPTH - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (count_q != '0) state_d = READ;
      end
      READ: begin
        if (i_bpu_req && (starve_q < STV_W'(STARVE_LIM))) begin
          starve_d = starve_q + STV_W'(1);
        end else begin
          // Update owns the read port; new counter value is staged in the write register
          upd_rd      = 1'b1;
          starve_d    = '0;
          state_d     = WRITE;
          ram_we_d    = 1'b1;
          ram_waddr_d = head.addr;
          if (head.taken) ram_wdata_d = (i_ram_rdata == 2'b11) ? 2'b11 : i_ram_rdata + 2'b01;
          else            ram_wdata_d = (i_ram_rdata == 2'b00) ? 2'b00 : i_ram_rdata - 2'b01;
        end
      end
      WRITE: begin
        pop     = 1'b1;
        state_d = ((count_q != CNT_W'(1)) || push) ? READ : IDLE;
      end
      default: state_d = INIT;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: i_cmt_addr, taken: i_cmt_taken};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    cmt_ready_d = init_done_d && (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      starve_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      init_done_q <= 1'b0;
      cmt_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      starve_q    <= starve_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      init_done_q <= init_done_d;
      cmt_ready_q <= cmt_ready_d;
    end
  end

  // Lookups see the in-flight write to their own index
  assign o_ram_raddr = upd_rd ? head.addr : i_bpu_addr;
  assign o_bpu_valid = i_bpu_req && init_done_q && !upd_rd;
  assign o_bpu_bits  = (ram_we_q && (ram_waddr_q == i_bpu_addr)) ? ram_wdata_q : i_ram_rdata;
  assign o_ram_we    = ram_we_q;
  assign o_ram_waddr = ram_waddr_q;
  assign o_ram_wdata = ram_wdata_q;
  assign o_init_done = init_done_q;
  assign o_cmt_ready = cmt_ready_q;

endmodule

// File: tb/tb_xcore_if_bim_ctrl.sv
// Directed bench for xcore_if_bim_ctrl with a behavioural async-read RAM.
module tb_xcore_if_bim_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bpu_req = 1'b0;
  logic [9:0] bpu_addr = '0;
  logic       bpu_valid;
  logic [1:0] bpu_bits;
  logic       cmt_valid = 1'b0;
  logic [9:0] cmt_addr = '0;
  logic       cmt_taken = 1'b0;
  logic       cmt_ready;
  logic [9:0] ram_raddr;
  logic [1:0] ram_rdata;
  logic       ram_we;
  logic [9:0] ram_waddr;
  logic [1:0] ram_wdata;
  logic       init_done;

  int checks = 0;
  int errors = 0;

  logic [1:0] mem [1024];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  xcore_if_bim_ctrl dut (
    .i_sys_clk  (clk),
    .i_sys_rst  (rst),
    .i_bpu_req  (bpu_req),
    .i_bpu_addr (bpu_addr),
    .o_bpu_valid(bpu_valid),
    .o_bpu_bits (bpu_bits),
    .i_cmt_valid(cmt_valid),
    .i_cmt_addr (cmt_addr),
    .i_cmt_taken(cmt_taken),
    .o_cmt_ready(cmt_ready),
    .o_ram_raddr(ram_raddr),
    .i_ram_rdata(ram_rdata),
    .o_ram_we   (ram_we),
    .o_ram_waddr(ram_waddr),
    .o_ram_wdata(ram_wdata),
    .o_init_done(init_done)
  );

  typedef struct {
    logic       req;
    logic [9:0] addr;
    logic       cv;
    logic [9:0] ca;
    logic       ct;
    logic       e_we;
    logic [9:0] e_waddr;
    logic [1:0] e_wdata;
    logic       e_valid;
    logic [1:0] e_bits;
    logic       e_ready;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole clear sweep: one write per cycle, done flag rises with the last one
  task automatic do_sweep();
    for (int k = 0; k < 1024; k++) begin
      tick();
      chk("sweep", 32'({ram_we, ram_waddr, ram_wdata, init_done}),
          32'({1'b1, 10'(k), 2'b01, (k == 1023)}));
    end
  endtask

  initial begin
    vt[0]  = '{1'b0, 10'h000, 1'b1, 10'h02A, 1'b1, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[1]  = '{1'b0, 10'h000, 1'b1, 10'h02A, 1'b1, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[2]  = '{1'b0, 10'h000, 1'b1, 10'h02A, 1'b1, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[3]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 10'h02A, 2'd2, 1'b0, 2'd0, 1'b1};
    vt[4]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[5]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 10'h02A, 2'd3, 1'b0, 2'd0, 1'b1};
    vt[6]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[7]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 10'h02A, 2'd3, 1'b0, 2'd0, 1'b1};
    vt[8]  = '{1'b1, 10'h02A, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0, 1'b1, 2'd3, 1'b1};
    vt[9]  = '{1'b0, 10'h000, 1'b1, 10'h007, 1'b0, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[10] = '{1'b0, 10'h000, 1'b1, 10'h007, 1'b0, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[11] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[12] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 10'h007, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[13] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[14] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 10'h007, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[15] = '{1'b1, 10'h007, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0, 1'b1, 2'd0, 1'b1};
    vt[16] = '{1'b0, 10'h000, 1'b1, 10'h010, 1'b1, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[17] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[18] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0, 1'b0, 2'd0, 1'b1};
    vt[19] = '{1'b1, 10'h010, 1'b0, 10'h000, 1'b0, 1'b1, 10'h010, 2'd2, 1'b1, 2'd2, 1'b1};
    vt[20] = '{1'b1, 10'h010, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0, 1'b1, 2'd2, 1'b1};

    // Held in reset: nothing enabled, even with a lookup pending
    bpu_req = 1'b1;
    bpu_addr = 10'h005;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(cmt_ready), 32'd0);
    chk("rst_valid", 32'(bpu_valid), 32'd0);
    rst = 1'b0;
    bpu_req = 1'b0;

    do_sweep();
    chk("init_ready", 32'(cmt_ready), 32'd1);

    tick();
    bpu_req = 1'b1;
    bpu_addr = 10'h005;
    #1;
    chk("post_init_we", 32'(ram_we), 32'd0);
    chk("lookup5_valid", 32'(bpu_valid), 32'd1);
    chk("lookup5_bits", 32'(bpu_bits), 32'd1);

    // Saturation, underflow and forwarding vectors
    for (int i = 0; i < 21; i++) begin
      tick();
      bpu_req = vt[i].req;
      bpu_addr = vt[i].addr;
      cmt_valid = vt[i].cv;
      cmt_addr = vt[i].ca;
      cmt_taken = vt[i].ct;
      #1;
      chk($sformatf("v%0d_valid", i), 32'(bpu_valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid) chk($sformatf("v%0d_bits", i), 32'(bpu_bits), 32'(vt[i].e_bits));
      chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vt[i].e_we));
      if (vt[i].e_we)
        chk($sformatf("v%0d_wr", i), 32'({ram_waddr, ram_wdata}), 32'({vt[i].e_waddr, vt[i].e_wdata}));
      chk($sformatf("v%0d_ready", i), 32'(cmt_ready), 32'(vt[i].e_ready));
    end

    // Starvation: fill FIFO under continuous lookups, forced update read after 8 grants
    tick();
    bpu_req = 1'b1;
    bpu_addr = 10'h100;
    cmt_valid = 1'b1;
    cmt_taken = 1'b1;
    cmt_addr = 10'h050;
    #1;
    chk("st_c0_valid", 32'(bpu_valid), 32'd1);
    tick();
    cmt_addr = 10'h051;
    tick();
    cmt_addr = 10'h052;
    #1;
    chk("st_c2_valid", 32'(bpu_valid), 32'd1);
    tick();
    cmt_addr = 10'h053;
    #1;
    chk("st_c3_ready", 32'(cmt_ready), 32'd1);
    tick();
    cmt_valid = 1'b0;
    #1;
    chk("st_full_ready", 32'(cmt_ready), 32'd0);
    chk("st_c4_valid", 32'(bpu_valid), 32'd1);
    for (int c = 5; c <= 9; c++) begin
      tick();
      chk($sformatf("st_c%0d_valid", c), 32'(bpu_valid), 32'd1);
    end
    tick();
    chk("st_forced_valid", 32'(bpu_valid), 32'd0);
    chk("st_forced_raddr", 32'(ram_raddr), 32'h050);
    chk("st_forced_ready", 32'(cmt_ready), 32'd0);
    tick();
    chk("st_write", 32'({ram_we, ram_waddr, ram_wdata}), 32'({1'b1, 10'h050, 2'd2}));
    chk("st_write_valid", 32'(bpu_valid), 32'd1);
    tick();
    bpu_req = 1'b0;
    #1;
    chk("st_ready_back", 32'(cmt_ready), 32'd1);
    repeat (8) tick();
    chk("st_drained_we", 32'(ram_we), 32'd0);

    // Reset during WRITE with three queued updates
    cmt_valid = 1'b1;
    cmt_taken = 1'b1;
    cmt_addr = 10'h060;
    tick();
    cmt_addr = 10'h061;
    tick();
    cmt_addr = 10'h062;
    tick();
    cmt_valid = 1'b0;
    #1;
    chk("mid_write", 32'({ram_we, ram_waddr, ram_wdata}), 32'({1'b1, 10'h060, 2'd2}));
    bpu_req = 1'b1;
    bpu_addr = 10'h060;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(ram_we), 32'd0);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    chk("mid_rst_ready", 32'(cmt_ready), 32'd0);
    chk("mid_rst_valid", 32'(bpu_valid), 32'd0);
    bpu_req = 1'b0;
    tick();
    rst = 1'b0;
    do_sweep();
    // Discarded updates must never be applied
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("flushed_we%0d", c), 32'(ram_we), 32'd0);
    end
    bpu_req = 1'b1;
    bpu_addr = 10'h061;
    #1;
    chk("flushed_bits", 32'({bpu_valid, bpu_bits}), 32'({1'b1, 2'd1}));
    chk("flushed_ready", 32'(cmt_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xcore_if_bim_ctrl.md
Name: xcore_if_bim_ctrl

Overview:
Controller for the 1024-entry 2-bit BIM counter RAM of the Xcore G-share BPU. Clears the table after reset and owns the RAM write port. Buffers commit-stage branch outcomes in a small FIFO and applies each as a saturating read-modify-write. Shares the single RAM read port between front-end lookups and update reads.

Parameters:
ADDR_W, 10, BIM index width
DEPTH, 1024, number of counters (2**ADDR_W)
FIFO_DEPTH, 4, commit update queue entries (power of 2)
INIT_VAL, 2'b01, counter value written during init sweep (weakly not-taken)
STARVE_LIM, 8, consecutive front-end-blocked cycles before an update read is forced

Ports:
i_sys_clk  in  1  system clock, all state on rising edge
i_sys_rst  in  1  asynchronous, active-high reset
i_bpu_req  in  1  front-end lookup request
i_bpu_addr  in  ADDR_W  lookup index
o_bpu_valid  out  1  o_bpu_bits valid this cycle (combinational)
o_bpu_bits  out  2  counter value for i_bpu_addr
i_cmt_valid  in  1  commit update offered
i_cmt_addr  in  ADDR_W  index to update
i_cmt_taken  in  1  resolved direction (1 = taken)
o_cmt_ready  out  1  FIFO can accept (registered, = !full && init done)
o_ram_raddr  out  ADDR_W  RAM async read address
i_ram_rdata  in  2  RAM async read data
o_ram_we  out  1  RAM write enable
o_ram_waddr  out  ADDR_W  RAM write address
o_ram_wdata  out  2  RAM write data
o_init_done  out  1  init sweep complete

Behaviour:
- Reset (async, any state): FSM->INIT, sweep counter=0, FIFO empty, starve counter=0, captured-data register=0. Outputs: o_init_done=0, o_cmt_ready=0, o_ram_we=0, o_bpu_valid=0.
- FSM states: INIT, IDLE, READ, WRITE.
- INIT: o_ram_we=1, waddr=sweep counter, wdata=INIT_VAL, one entry per cycle. After writing DEPTH-1, go to IDLE and set o_init_done=1; sweep takes exactly DEPTH cycles. Front-end and commit are ignored throughout.
- IDLE: if FIFO non-empty, go to READ; else stay.
- READ: the read port is granted to the front end when i_bpu_req=1 and starve counter < STARVE_LIM.
  - Front-end grant: starve counter increments; FSM stays in READ.
  - Otherwise: o_ram_raddr = FIFO head addr; i_ram_rdata is captured; starve counter clears; go to WRITE.
- WRITE:
  - o_ram_we=1, waddr = head addr, wdata = sat(old+1) if taken else sat(old-1), saturating at 3 and 0.
  - Pop FIFO; go to READ if FIFO still holds another entry after the pop, else IDLE.
- Front-end path:
  - o_ram_raddr = i_bpu_addr whenever the read port is not granted to an update.
  - o_bpu_valid = i_bpu_req && o_init_done && !(forced update read this cycle).
  - o_bpu_bits = i_ram_rdata, except when o_ram_we=1 and o_ram_waddr==i_bpu_addr: forward o_ram_wdata.
  - Zero-cycle lookup latency.
- FIFO:
  - Push on i_cmt_valid && o_cmt_ready.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No coalescing; same-address entries are applied in order. Each RMW reads after the prior write has landed, because READ follows WRITE.
- Starve counter saturates at STARVE_LIM. A forced update read occurs on the cycle the counter equals STARVE_LIM with i_bpu_req=1.
- Update throughput: 2 cycles per entry when the front end is idle.
- Reset mid-sweep or mid-RMW: all queued updates are discarded and the sweep restarts at 0.

Test Plan:
- Reset then idle for 1024 cycles -> o_ram_we=1 on each cycle with waddr 0..1023 and wdata=01; o_init_done rises on cycle 1024; lookup of addr 5 returns 01 with valid=1.
- After init, commit addr 0x2A taken three times, front end idle -> writes 10, 11, 11 (saturates); lookup 0x2A returns 11.
- Commit addr 7 not-taken twice -> writes 00 then 00; no underflow.
- Push 4 entries with no drain (front end requesting continuously) -> o_cmt_ready=0 after the 4th. After STARVE_LIM=8 blocked cycles, one cycle has o_bpu_valid=0 and the update read proceeds; ready returns to 1 after the pop.
- Lookup addr 0x10 in the same cycle as the WRITE to 0x10 (old 01, taken) -> o_bpu_bits=10 (forwarded).
- Assert i_sys_rst during WRITE with 3 queued entries -> immediately o_ram_we=0, o_init_done=0, FIFO empty; after release the sweep restarts from addr 0.
